// File: rtl/sram_req_ctrl_pkg.sv
// Shared defaults and credit helper for the SRAM request controller and its response FIFO.
package sram_ctrl_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_RSP_DEPTH = 3;

  // Every outstanding read owns one response slot, so the credit pool equals the FIFO depth.
  function automatic int credit_limit(input int rsp_depth);
    return rsp_depth;
  endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response channel between the event-processing initiator and the SRAM controller.
interface sram_req_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEF_DEPTH)
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [AW-1:0]      req_addr;
  logic [WIDTH/8-1:0] req_wmask;
  logic [WIDTH-1:0]   req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_req_ctrl_chk.sv
// Protocol checks for the SRAM request controller: no FIFO overflow, no SRAM access in reset.
module sram_req_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full,
  input logic sram_ce
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

  a_no_access_in_reset: assert property (@(posedge clk) rst |-> !sram_ce);

endmodule

// File: rtl/sram_rsp_fifo.sv
// Generic synchronous FIFO with occupancy count; head entry is presented without a pop.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_RSP_DEPTH,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Qualify push/pop against occupancy and expose status flags
  always_comb begin
    empty     = (count_r == {CW{1'b0}});
    full      = (count_r == CW'(DEPTH));
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    count     = count_r;
    pop_data  = mem_r[rd_ptr_r];
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for a single-port byte-masked SRAM with one-cycle registered read.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH,
  localparam int AW       = $clog2(DEPTH),
  localparam int BW       = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  sram_req_ctrl_if.slave   bus,
  output logic             sram_ce,
  output logic             sram_we,
  output logic [AW-1:0]    sram_addr,
  output logic [BW-1:0]    sram_wmask,
  output logic [WIDTH-1:0] sram_wdata,
  input  logic [WIDTH-1:0] sram_rdata,
  output logic             busy
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int UW = CW + 1;

  logic             rd_pending_r;
  logic             req_ready_s;
  logic             fire_s;
  logic             wr_fire_s;
  logic             rd_fire_s;
  logic [UW-1:0]    used_s;
  logic             rsp_valid_s;
  logic             pop_s;
  logic [CW-1:0]    fifo_count_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic [WIDTH-1:0] fifo_head_s;

  // Credit check and zero-latency SRAM drive from the accepted request
  always_comb begin
    used_s = UW'(fifo_count_s) + UW'(rd_pending_r);
    if (rst) begin
      req_ready_s = 1'b0;
    end else begin
      req_ready_s = (used_s < UW'(credit_limit(RSP_DEPTH)));
    end
    fire_s     = bus.req_valid & req_ready_s;
    wr_fire_s  = fire_s & bus.req_we;
    rd_fire_s  = fire_s & ~bus.req_we;
    sram_ce    = fire_s;
    sram_we    = wr_fire_s;
    sram_addr  = bus.req_addr;
    sram_wdata = bus.req_wdata;
    if (wr_fire_s) begin
      sram_wmask = bus.req_wmask;
    end else begin
      sram_wmask = {BW{1'b0}};
    end
  end

  // Response side status; gated by reset so nothing is offered while it is held
  always_comb begin
    rsp_valid_s = ~rst & ~fifo_empty_s;
    pop_s       = rsp_valid_s & bus.rsp_ready;
    busy        = ~rst & (rd_pending_r | ~fifo_empty_s);
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_rdata = fifo_head_s;

  // A read accepted at this edge has its data on sram_rdata during the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending_r <= 1'b0;
    end else begin
      rd_pending_r <= rd_fire_s;
    end
  end

  sram_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending_r),
    .push_data (sram_rdata),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  sram_req_ctrl_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .push    (rd_pending_r),
    .full    (fifo_full_s),
    .sram_ce (sram_ce)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural byte-masked SRAM and in-order response check.
module tb_sram_req_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_init;
  logic        sram_ce;
  logic        sram_we;
  logic [3:0]  sram_addr;
  logic [1:0]  sram_wmask;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        busy;
  logic [15:0] mem [16];
  logic [15:0] exp_q [$];
  int          n_vec;
  int          n_miss;

  sram_req_ctrl_if #(.WIDTH(16), .AW(4)) bus ();

  sram_req_ctrl #(.WIDTH(16), .DEPTH(16), .RSP_DEPTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: masked write at the edge, registered read
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hC000 + 16'(i);
      sram_rdata <= 16'h0000;
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 2; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'd0;
    bus.req_wmask = 2'b00;
    bus.req_wdata = 16'h0000;
  endtask

  task automatic set_req(input logic we, input logic [3:0] addr, input logic [1:0] mask,
                         input logic [15:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wmask = mask;
    bus.req_wdata = data;
  endtask

  // Every popped response must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) check_eq("rsp_unexpected", 32'd1, 32'd0);
        else check_eq("rsp_data", {16'h0000, bus.rsp_rdata}, {16'h0000, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int  acc;
    bit  rdy;
    bit  fired;
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    mem_init = 1'b1;
    bus.rsp_ready = 1'b0;
    idle();
    tick();
    mem_init = 1'b0;
    tick();
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(bus.req_ready), 32'd1);
    tick();

    // Back-to-back stream of reads 0..15
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        set_req(1'b0, 4'(i), 2'b11, 16'h0000);
        exp_q.push_back(16'hC000 + 16'(i));
        #1;
        check_eq("stream_ready", 32'(bus.req_ready), 32'd1);
        check_eq("stream_rd_wmask", 32'(sram_wmask), 32'd0);
      end else begin
        idle();
      end
      tick();
      check_eq("stream_rsp_valid", 32'(bus.rsp_valid), (i >= 1 && i <= 16) ? 32'd1 : 32'd0);
    end
    check_eq("stream_busy_idle", 32'(busy), 32'd0);

    // Write then read with two-cycle latency
    set_req(1'b1, 4'd3, 2'b11, 16'hA5A5);
    #1;
    check_eq("wr_ce", 32'(sram_ce), 32'd1);
    check_eq("wr_we", 32'(sram_we), 32'd1);
    tick();
    set_req(1'b0, 4'd3, 2'b11, 16'h0000);
    exp_q.push_back(16'hA5A5);
    tick();
    idle();
    check_eq("lat_n0", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_eq("lat_n1", 32'(bus.rsp_valid), 32'd1);
    check_eq("lat_data", 32'(bus.rsp_rdata), 32'h0000A5A5);
    tick();

    // Byte-masked merge
    set_req(1'b1, 4'd5, 2'b11, 16'h1234);
    tick();
    set_req(1'b1, 4'd5, 2'b10, 16'hABCD);
    #1;
    check_eq("mask_pins", 32'(sram_wmask), 32'd2);
    tick();
    set_req(1'b0, 4'd5, 2'b11, 16'h0000);
    exp_q.push_back(16'hAB34);
    tick();
    idle();
    tick();
    tick();
    check_eq("mask_mem", 32'(mem[5]), 32'h0000AB34);

    // Backpressure: only three reads fit
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      set_req(1'b0, 4'(8 + acc), 2'b11, 16'h0000);
      #1;
      rdy = bus.req_ready;
      if (rdy) exp_q.push_back(16'hC000 + 16'(8 + acc));
      tick();
      if (rdy) acc++;
    end
    check_eq("bp_accepted", 32'(acc), 32'd3);
    check_eq("bp_ready_low", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10 && acc < 5; c++) begin
      set_req(1'b0, 4'(8 + acc), 2'b11, 16'h0000);
      #1;
      rdy = bus.req_ready;
      if (rdy) exp_q.push_back(16'hC000 + 16'(8 + acc));
      tick();
      if (rdy) acc++;
    end
    idle();
    check_eq("bp_total", 32'(acc), 32'd5);
    for (int c = 0; c < 6; c++) tick();
    check_eq("bp_drained", 32'(exp_q.size()), 32'd0);
    check_eq("bp_busy", 32'(busy), 32'd0);

    // Credits exhausted with a write waiting
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, 4'(i), 2'b11, 16'h0000);
      exp_q.push_back(16'hC000 + 16'(i));
      tick();
    end
    set_req(1'b1, 4'd7, 2'b11, 16'h5555);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("cr_ready", 32'(bus.req_ready), 32'd0);
      check_eq("cr_ce", 32'(sram_ce), 32'd0);
      tick();
    end
    check_eq("cr_mem_hold", 32'(mem[7]), 32'h0000C007);
    bus.rsp_ready = 1'b1;
    fired = 1'b0;
    for (int c = 0; c < 8 && !fired; c++) begin
      #1;
      fired = bus.req_ready;
      tick();
    end
    idle();
    check_eq("cr_fired", 32'(fired), 32'd1);
    check_eq("cr_mem_write", 32'(mem[7]), 32'h00005555);
    for (int c = 0; c < 5; c++) tick();
    check_eq("cr_drained", 32'(exp_q.size()), 32'd0);

    // Reset with reads in flight and a write presented
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 4'd4, 2'b11, 16'h0000);
    tick();
    set_req(1'b0, 4'd5, 2'b11, 16'h0000);
    tick();
    rst = 1'b1;
    exp_q.delete();
    set_req(1'b1, 4'd9, 2'b11, 16'hDEAD);
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_ce", 32'(sram_ce), 32'd0);
      check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    rst = 1'b0;
    idle();
    #1;
    check_eq("rel_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rel_busy", 32'(busy), 32'd0);
    check_eq("rel_mem9", 32'(mem[9]), 32'h0000C009);
    bus.rsp_ready = 1'b1;
    tick();
    check_eq("rel_no_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
Initiator-side controller for the single-port byte-masked SRAM macro model (ce/we/wmask/addr/wdata/rdata, one-cycle registered read).
- Accepts read/write requests on a valid/ready channel.
- Drives the SRAM pins and returns read data on a separate valid/ready response channel.
- Buffers read data in a small response FIFO so the SRAM keeps streaming when the consumer stalls.
- Sits between event-processing logic and each SRAM instance.

Parameters:
WIDTH, 16, data width in bits; multiple of 8.
DEPTH, 16, SRAM words; AW = $clog2(DEPTH).
RSP_DEPTH, 3, response FIFO entries; must be >=2; full read throughput requires >=3.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request valid.
req_ready  output  1  request accepted when valid&ready (fire).
req_we  input  1  1 = write, 0 = read.
req_addr  input  AW  word address.
req_wmask  input  WIDTH/8  byte write enables (bit i covers bits 8i+7:8i).
req_wdata  input  WIDTH  write data.
rsp_valid  output  1  read response valid.
rsp_ready  input  1  consumer accepts response.
rsp_rdata  output  WIDTH  read data, head of FIFO.
sram_ce  output  1  SRAM chip enable.
sram_we  output  1  SRAM write enable.
sram_addr  output  AW  SRAM address.
sram_wmask  output  WIDTH/8  SRAM byte mask.
sram_wdata  output  WIDTH  SRAM write data.
sram_rdata  input  WIDTH  SRAM read data, valid the cycle after a read edge.
busy  output  1  read pending or FIFO non-empty.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: req_ready=0 while rst=1, rsp_valid=0, sram_ce=0, sram_we=0, busy=0; FIFO pointers, count and rd_pending=0.
- Credits: req_ready = !rst && (fifo_count + rd_pending) < RSP_DEPTH.
  - Same formula for reads and writes; no combinational path from req_we or rsp_ready to req_ready.
- SRAM drive is combinational from the request (zero added latency):
  - sram_ce = fire; sram_we = fire & req_we.
  - sram_addr, sram_wmask and sram_wdata pass through from the request.
  - sram_wmask is forced to 0 when not a write fire.
- Writes are posted: there is no response, and the data is committed at the fire edge.
- Read at edge N: rd_pending=1 after N; sram_rdata is pushed into the FIFO at edge N+1; rsp_valid is high after N+1.
  - Latency is 2 cycles from accept to rsp_valid when the FIFO is empty.
- Pop on rsp_valid & rsp_ready. Push and pop in the same edge is legal; count unchanged.
- Pointers wrap modulo RSP_DEPTH. Overflow is impossible by credit; an assertion fires if a push occurs when count==RSP_DEPTH.
- Responses are returned strictly in request order.
- Read-after-write to the same address returns the new data: the SRAM is single-port and requests are issued in order.
- Response data is held stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation:
  - Pending read is discarded.
  - FIFO is flushed.
  - No SRAM access is issued during reset, even if req_valid=1.
- busy = rd_pending | (fifo_count != 0).

Decomposition:
- Package sram_ctrl_pkg holds the default constants DEF_WIDTH=16, DEF_DEPTH=16, DEF_RSP_DEPTH=3.
- The package also holds a function that computes the credit threshold.
- Sub-module sram_rsp_fifo: generic synchronous FIFO (WIDTH, DEPTH; push/pop/count/empty/full). It is reused by other blocks.
- Credit logic and rd_pending stay in the top module.

Test Plan:
1. Reset: rst=1 for 2 cycles mid-stream with reads in flight. -> rsp_valid=0, busy=0, sram_ce=0 throughout reset; req_ready=1 the cycle after release.
2. Write 0xA5A5 to addr 3 (wmask 2'b11), then read addr 3 with rsp_ready=1. -> rsp_rdata=0xA5A5, rsp_valid 2 cycles after read accept.
3. Byte mask: write 0x1234 to addr 5 with mask 11, then 0xABCD with mask 10, then read addr 5. -> 0xAB34.
4. Stream reads of addr 0..15 back-to-back with rsp_ready=1. -> 16 in-order responses on consecutive cycles; req_ready never drops.
5. Backpressure: rsp_ready=0, attempt 5 reads. -> exactly 3 accepted, then req_ready=0. Raise rsp_ready -> 3 in-order responses, remaining 2 accepted, order preserved.
6. Credits exhausted with a write request pending. -> req_ready=0, sram_ce=0, memory unchanged until a pop frees a credit.
